prio_encoder_pend: RTL and testbench
====================================

# prio_encoder_pend

Parametrised, registered priority encoder with sticky request capture. It is the next generation of the team's 8-to-3 non-priority encoder. It accepts any number of simultaneous one-hot or multi-hot requests on N lines, holds each request pending until it is serviced, and presents one encoded index at a time over a valid/ready handshake. Fixed-priority or round-robin selection is chosen by parameter. It sits between raw event/interrupt lines and a single-index consumer.

## Interface
- N, 8: number of request lines; N >= 2.
- IW, $clog2(N): index width; derived, do not override.
- MODE, 0: selection mode; 0 = fixed (lowest index wins, d[0] maps to index 0), 1 = round-robin.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- d  in  N  request lines, sampled every cycle; multi-hot allowed.
- mask  in  N  1 = line ineligible for selection; its pending bit is retained.
- y  out  IW  encoded index of the presented request.
- y_valid  out  1  y holds a serviced request.
- y_ready  in  1  consumer accepts y when y_valid && y_ready.
- multi  out  1  more than one line was eligible when y was loaded.

## Operation
- pend[N-1:0] is a sticky register. Each edge: pend <= (pend | d) & ~clr, where clr is the one-hot of an index loaded into y that edge (else 0).
- eligible = (pend | d) & ~mask, evaluated combinationally.
- Two-state FSM:
  - IDLE (y_valid = 0): if eligible != 0, load y = pick(eligible), set multi, set clr, go to HOLD.
  - HOLD (y_valid = 1): y and multi are frozen while y_ready = 0.
  - On y_ready = 1 in HOLD: if eligible (excluding nothing further; the current index is already cleared) != 0, load the next pick the same edge and stay in HOLD (back-to-back). Otherwise go to IDLE.
- Fixed mode: pick = lowest set index.
- Round-robin mode: ptr (IW bits) = last loaded index + 1, wrapping N-1 -> 0. pick = first set index searching upward from ptr with wrap. ptr updates only on a load.
- The loaded bit is cleared even if d[idx] is high the same edge. A request still high the next cycle re-pends.
- Masked lines accumulate in pend. Unmasking makes them eligible on the same cycle.
- If N is not a power of two, indices >= N never occur. ptr wraps at N-1, not 2^IW - 1.
- multi = popcount(eligible) > 1 at the load edge.

## Timing
- Reset (asynchronous assert, synchronous use after deassert): pend = 0, y = 0, y_valid = 0, multi = 0, ptr = 0, FSM = IDLE.
- Latency: d asserted in cycle t produces y_valid = 1 with y valid after edge t (1 cycle).
- Throughput: one index per cycle when y_ready is held high and requests remain.
- y, y_valid and multi must not change while y_valid && !y_ready. Exception: reset.
- Simultaneous accept and new d on the same edge: the new d participates in the same-edge next pick.
- Reset mid-HOLD: the presented index and all pending requests are discarded.

## Structure
- Shared package prio_pkg: MODE_FIXED = 0, MODE_RR = 1.
- Sub-module prio_pick: combinational find-first-set over N bits from a start position with wrap, parametrised by N. Outputs are index, found, and multi.
  - Fixed mode uses start = 0.
  - The top level contains pend, the FSM, ptr and the output register.

## Test plan
- Reset and idle: rst pulse with d = 0 -> y = 0, y_valid = 0, multi = 0; d = 0 for 10 cycles -> y_valid stays 0.
- Single pulse, N = 8, fixed: d = 8'b0001_0000 for one cycle, y_ready = 1 -> next cycle y = 3'd4, y_valid = 1, multi = 0; following cycle y_valid = 0.
- Multi-hot, fixed, back-to-back: d = 8'b0100_0101 for one cycle, y_ready = 1 -> y = 0, 2, 6 on consecutive cycles; multi = 1, 1, 0; then y_valid = 0.
- Backpressure and sticky capture: y_ready = 0, d = 8'b0000_0010, then d = 8'b1000_0000 one cycle later -> y = 1 held stable; raise y_ready -> y = 7 next cycle, no request lost.
- Mask: mask = 8'hFF, d = 8'b0000_1000 pulse -> y_valid stays 0; clear mask -> y = 3 next cycle.
- Round-robin, N = 5: d = 5'b11111 held, y_ready = 1 -> y sequence 0, 1, 2, 3, 4, 0 (wrap at N-1). Async rst mid-sequence -> y_valid = 0 immediately, restart at 0.

Source files
------------

// File: rtl/prio_pkg.sv
// Shared definitions for the pending-request priority encoder:
// selection modes and the two-state presentation FSM encoding.
package prio_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/prio_pick.sv
// Combinational find-first-set over N bits, searching upward from a start
// position with wrap at N-1; also flags when more than one bit is set.
module prio_pick #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  vec,
    input  logic [IW-1:0] start,
    output logic [IW-1:0] idx,
    output logic          found,
    output logic          multi
);

    int            p;
    int            cnt;
    logic [IW-1:0] pos;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        cnt   = 0;
        p     = 0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            if (vec[k]) cnt = cnt + 1;
            // Wrap explicitly at N so non-power-of-two widths never yield idx >= N.
            p = int'(start) + k;
            if (p >= N) p = p - N;
            pos = IW'(p);
            if (!found && vec[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
        multi = (cnt > 1);
    end

endmodule

// File: rtl/prio_encoder_pend.sv
// Registered priority encoder with sticky request capture: requests pend until
// loaded into y, which is presented over a valid/ready handshake.
module prio_encoder_pend
    import prio_pkg::*;
#(
    parameter int N    = 8,
    parameter int IW   = $clog2(N),
    parameter int MODE = MODE_FIXED
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  d,
    input  logic [N-1:0]  mask,
    output logic [IW-1:0] y,
    output logic          y_valid,
    input  logic          y_ready,
    output logic          multi
);

    state_t        state;
    logic [N-1:0]  pend;
    logic [N-1:0]  req;
    logic [N-1:0]  eligible;
    logic [N-1:0]  clr;
    logic [IW-1:0] ptr;
    logic [IW-1:0] start;
    logic [IW-1:0] pick_idx;
    logic          pick_found;
    logic          pick_multi;
    logic          load;

    // Same-cycle d participates, so a pulse or an unmask is seen without delay.
    assign req      = pend | d;
    assign eligible = req & ~mask;
    assign start    = (MODE == MODE_RR) ? ptr : '0;

    prio_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .vec   (eligible),
        .start (start),
        .idx   (pick_idx),
        .found (pick_found),
        .multi (pick_multi)
    );

    // Load from IDLE whenever something is eligible, or back-to-back on accept.
    assign load = pick_found && ((state == ST_IDLE) || y_ready);

    always_comb begin
        clr = '0;
        if (load) clr[pick_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            pend    <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            multi   <= 1'b0;
            ptr     <= '0;
        end else begin
            // The loaded bit is dropped even if d holds it high this edge.
            pend <= req & ~clr;
            if (load) begin
                state   <= ST_HOLD;
                y       <= pick_idx;
                multi   <= pick_multi;
                y_valid <= 1'b1;
                ptr     <= (pick_idx == IW'(N - 1)) ? '0 : pick_idx + IW'(1);
            end else if ((state == ST_HOLD) && y_ready) begin
                state   <= ST_IDLE;
                y_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prio_encoder_pend.sv
// Scoreboard bench: directed stimulus pushes expected (y, multi) pairs; a
// negedge monitor pops and compares on every accepted handshake.
module tb_prio_encoder_pend;
    import prio_pkg::*;

    typedef struct {
        int y;
        int m;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [7:0] d8    = '0;
    logic [7:0] mask8 = '0;
    logic       rdy8  = 1'b0;
    logic [2:0] y8;
    logic       v8;
    logic       m8;

    logic [4:0] d5    = '0;
    logic [4:0] mask5 = '0;
    logic       rdy5  = 1'b0;
    logic [2:0] y5;
    logic       v5;
    logic       m5;

    exp_t q8[$];
    exp_t q5[$];
    exp_t e8;
    exp_t e5;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    prio_encoder_pend #(.N(8), .MODE(MODE_FIXED)) dut8 (
        .clk     (clk),
        .rst     (rst),
        .d       (d8),
        .mask    (mask8),
        .y       (y8),
        .y_valid (v8),
        .y_ready (rdy8),
        .multi   (m8)
    );

    prio_encoder_pend #(.N(5), .MODE(MODE_RR)) dut5 (
        .clk     (clk),
        .rst     (rst),
        .d       (d5),
        .mask    (mask5),
        .y       (y5),
        .y_valid (v5),
        .y_ready (rdy5),
        .multi   (m5)
    );

    task automatic check(input string nm, input int act, input int exp);
        total = total + 1;
        if (act == exp) passed = passed + 1;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push8(input int y, input int m);
        exp_t e;
        e.y = y;
        e.m = m;
        q8.push_back(e);
    endtask

    task automatic push5(input int y, input int m);
        exp_t e;
        e.y = y;
        e.m = m;
        q5.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (v8 && rdy8) begin
                if (q8.size() == 0) begin
                    check("n8_unexpected_y", int'(y8), -1);
                end else begin
                    e8 = q8.pop_front();
                    check("n8_y", int'(y8), e8.y);
                    check("n8_multi", int'(m8), e8.m);
                end
            end
            if (v5 && rdy5) begin
                if (q5.size() == 0) begin
                    check("n5_unexpected_y", int'(y5), -1);
                end else begin
                    e5 = q5.pop_front();
                    check("n5_y", int'(y5), e5.y);
                    check("n5_multi", int'(m5), e5.m);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and idle
        tick();
        check("reset_y", int'(y8), 0);
        check("reset_valid", int'(v8), 0);
        check("reset_multi", int'(m8), 0);
        check("reset_valid5", int'(v5), 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_valid", int'(v8), 0);
        end

        // Single pulse, fixed
        rdy8 = 1'b1;
        d8   = 8'b0001_0000;
        push8(4, 0);
        tick();
        d8 = '0;
        check("pulse_valid", int'(v8), 1);
        tick();
        check("pulse_drop_valid", int'(v8), 0);

        // Multi-hot back-to-back, fixed
        d8 = 8'b0100_0101;
        push8(0, 1);
        push8(2, 1);
        push8(6, 0);
        tick();
        d8 = '0;
        tick();
        tick();
        tick();
        check("multihot_drain_valid", int'(v8), 0);

        // Backpressure with sticky capture
        rdy8 = 1'b0;
        d8   = 8'b0000_0010;
        push8(1, 0);
        push8(7, 0);
        tick();
        d8 = 8'b1000_0000;
        tick();
        d8 = '0;
        check("bp_y_held", int'(y8), 1);
        check("bp_valid_held", int'(v8), 1);
        tick();
        check("bp_y_held2", int'(y8), 1);
        check("bp_multi_held", int'(m8), 0);
        rdy8 = 1'b1;
        tick();
        check("bp_second_y", int'(y8), 7);
        tick();
        check("bp_drain_valid", int'(v8), 0);

        // Mask retains pending, unmask is seen the same cycle
        mask8 = 8'hFF;
        d8    = 8'b0000_1000;
        tick();
        d8 = '0;
        check("mask_valid0", int'(v8), 0);
        tick();
        check("mask_valid1", int'(v8), 0);
        push8(3, 0);
        mask8 = '0;
        tick();
        check("unmask_y", int'(y8), 3);
        tick();
        check("unmask_drain_valid", int'(v8), 0);

        // Round-robin N=5 with wrap, then async reset mid-sequence
        rdy5 = 1'b1;
        d5   = 5'b11111;
        push5(0, 1);
        push5(1, 1);
        push5(2, 1);
        push5(3, 1);
        push5(4, 1);
        push5(0, 1);
        for (int i = 0; i < 6; i++) tick();
        #5;
        rst = 1'b1;
        d5  = '0;
        #1;
        check("rr_rst_valid", int'(v5), 0);
        check("rr_rst_y", int'(y5), 0);
        check("rr_rst_multi", int'(m5), 0);
        tick();
        rst = 1'b0;
        d5  = 5'b00101;
        push5(0, 1);
        push5(2, 0);
        tick();
        d5 = '0;
        check("rr_restart_y", int'(y5), 0);
        tick();
        tick();
        check("rr_drain_valid", int'(v5), 0);

        check("q8_empty", q8.size(), 0);
        check("q5_empty", q5.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
